fifo_uart_tx: RTL and testbench

// - Downstream drain stage for synchronous_fifo. Pops bytes from the FIFO's show-ahead read port
//   and serialises each one as an asynchronous UART frame on tx.
// - Frame: start bit, data LSB first, optional parity bit, then 1 or 2 stop bits.
// - Used as the off-chip byte egress path; the FIFO absorbs bursts while this block paces output.

---
 rtl/fifo_uart_tx.sv | 90 +++++++++
 tb/tb_fifo_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead FIFO and serialises each byte as a UART frame
// Ports: clk/rst (sync, active-high); fifo_dout/fifo_empty from the FIFO head;
// fifo_rd_en pop strobe (combinational); tx serial line (registered, idles high);
// busy high while a frame is in flight; frame_done one-cycle pulse on the last stop cycle.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q;
  logic [BW-1:0]         baud_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_q, busy_q, done_q;
  logic                  bit_end, last_stop;
  assign bit_end    = baud_q == BW'(CLKS_PER_BIT - 1);
  assign last_stop  = idx_q == IW'(STOP_BITS - 1);
  assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !rst;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  // idx_q doubles as the stop-bit counter in STOP; it is always zero on entry to each state that uses it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: if (fifo_rd_en) begin
          data_q  <= fifo_dout;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= START;
        end
        START: if (bit_end) begin
          tx_q    <= data_q[0];
          idx_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            idx_q   <= '0;
            tx_q    <= (PARITY_EN != 0) ? ((^data_q) ^ 1'(PARITY_ODD)) : 1'b1;
            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_q <= idx_q + 1'b1;
            tx_q  <= data_q[idx_q + 1'b1];
          end
        end
        PARITY: if (bit_end) begin
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: begin
          // registered pulse: raise one cycle early so it is visible on the final stop cycle
          done_q <= last_stop && baud_q == BW'(CLKS_PER_BIT - 2);
          if (bit_end) begin
            idx_q <= last_stop ? '0 : idx_q + 1'b1;
            if (last_stop) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx across four parameter sets
module tb_fifo_uart_tx;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]      empty, rd_en, tx, busy, done;
  logic [N-1:0][7:0] dout;
  logic [7:0]        mem [N][64];
  int                wp [N] = '{0, 0, 0, 0};
  logic [7:0]        exp_q [$];
  int                cyc = 0;
  int                n_chk = 0;
  int                n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < N; g++) begin : fm
    int rp = 0;
    assign empty[g] = (rp == wp[g]);
    assign dout[g]  = mem[g][rp[5:0]];
    always begin
      @(negedge clk);
      #3;
      if (rd_en[g]) begin
        @(posedge clk);
        #1;
        rp = rp + 1;
      end
    end
  end
  fifo_uart_tx u0 (.clk(clk), .rst(rst), .fifo_dout(dout[0]), .fifo_empty(empty[0]),
    .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));
  fifo_uart_tx #(.PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .fifo_dout(dout[1]), .fifo_empty(empty[1]),
    .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));
  fifo_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .fifo_dout(dout[2]),
    .fifo_empty(empty[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .fifo_dout(dout[3]),
    .fifo_empty(empty[3]), .fifo_rd_en(rd_en[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(done[3]));
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input int k, input logic [7:0] b);
    mem[k][wp[k][5:0]] = b;
    wp[k] = wp[k] + 1;
    exp_q.push_back(b);
  endtask
  task automatic rx_frame(input int k, input int cpb, input int pe, input int po, input int ns,
                          output logic par, output int len, output int t_pop);
    int total, bi, bad, dn;
    logic [7:0] e, got;
    logic ex;
    total = (1 + 8 + pe + ns) * cpb;
    bad = 0; dn = 0; len = -1; got = '0; par = 1'bx; t_pop = -1; e = '0;
    #1;
    for (int w = 0; w < 2000 && !rd_en[k]; w++) step();
    n_chk++;
    if (rd_en[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_wait[%0d]: rd_en=%b, required 1 within 2000 cycles", k, rd_en[k]);
      return;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    step();
    t_pop = cyc;
    for (int i = 0; i < total; i++) begin
      bi = i / cpb;
      ex = (bi == 0) ? 1'b0 : (bi <= 8) ? e[bi-1] : (pe != 0 && bi == 9) ? ((^e) ^ po[0]) : 1'b1;
      if (tx[k] !== ex || busy[k] !== 1'b1 || rd_en[k] !== 1'b0) bad++;
      if (done[k] === 1'b1) begin
        dn++;
        len = i + 1;
      end
      if (i % cpb == cpb / 2) begin
        if (bi >= 1 && bi <= 8) got[bi-1] = tx[k];
        else if (pe != 0 && bi == 9) par = tx[k];
      end
      step();
    end
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL data[%0d]: got %h, required %h", k, got, e);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pattern[%0d] byte %h: %0d bad cycles, required 0", k, e, bad);
    end
    n_chk++;
    if (dn != 1 || len != total) begin
      n_fail++;
      $display("FAIL frame_done[%0d]: %0d pulses ending frame at %0d, required 1 at %0d", k, dn, len, total);
    end
    n_chk++;
    if (busy[k] !== 1'b0 || tx[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_gap[%0d]: busy=%b tx=%b, required busy=0 tx=1", k, busy[k], tx[k]);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    push(0, 8'hA5);
    step();
    n_chk++;
    if (tx !== 4'hF) begin n_fail++; $display("FAIL reset_tx: %b, required 1111", tx); end
    n_chk++;
    if (busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy: %b, required 0000", busy); end
    n_chk++;
    if (done !== 4'h0) begin n_fail++; $display("FAIL reset_done: %b, required 0000", done); end
    n_chk++;
    if (rd_en !== 4'h0) begin n_fail++; $display("FAIL reset_rd_en: %b, required 0000", rd_en); end
    rst = 1'b0;
  endtask
  task automatic test_8n1();
    logic p;
    int l, t;
    rx_frame(0, 16, 0, 0, 1, p, l, t);
    n_chk++;
    if (l != 160) begin n_fail++; $display("FAIL 8n1_len: frame_done at %0d, required 159", l - 1); end
  endtask
  task automatic test_back_to_back();
    logic p;
    int l, t0, t1, t2;
    push(0, 8'h01);
    push(0, 8'h80);
    push(0, 8'hFF);
    rx_frame(0, 16, 0, 0, 1, p, l, t0);
    rx_frame(0, 16, 0, 0, 1, p, l, t1);
    rx_frame(0, 16, 0, 0, 1, p, l, t2);
    n_chk++;
    if (t1 - t0 != 161) begin n_fail++; $display("FAIL b2b_period1: %0d, required 161", t1 - t0); end
    n_chk++;
    if (t2 - t1 != 161) begin n_fail++; $display("FAIL b2b_period2: %0d, required 161", t2 - t1); end
  endtask
  task automatic test_empty();
    logic p;
    int l, t, bad;
    bad = 0;
    repeat (500) begin
      step();
      if (rd_en[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL empty_idle: %0d bad cycles, required 0", bad); end
    push(0, 8'h5A);
    rx_frame(0, 16, 0, 0, 1, p, l, t);
  endtask
  task automatic test_reset_mid();
    logic p;
    int l, t, dn;
    dn = 0;
    push(0, 8'h3C);
    push(0, 8'h96);
    #1;
    n_chk++;
    if (rd_en[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pop: rd_en=%b, required 1", rd_en[0]); end
    void'(exp_q.pop_front());
    step();
    repeat (50) begin
      step();
      if (done[0] === 1'b1) dn++;
    end
    rst = 1'b1;
    step();
    n_chk++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abort: tx=%b busy=%b, required tx=1 busy=0", tx[0], busy[0]);
    end
    if (done[0] === 1'b1) dn++;
    n_chk++;
    if (rd_en[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rd_en_rst: %b, required 0", rd_en[0]); end
    step();
    if (done[0] === 1'b1) dn++;
    n_chk++;
    if (dn != 0) begin n_fail++; $display("FAIL mid_no_done: %0d pulses, required 0", dn); end
    rst = 1'b0;
    rx_frame(0, 16, 0, 0, 1, p, l, t);
  endtask
  task automatic test_parity();
    logic p;
    int l, t;
    push(1, 8'h07);
    rx_frame(1, 16, 1, 0, 1, p, l, t);
    n_chk++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL par_even_07: %b, required 1", p); end
    n_chk++;
    if (l != 176) begin n_fail++; $display("FAIL par_len: %0d, required 176", l); end
    push(1, 8'h03);
    rx_frame(1, 16, 1, 0, 1, p, l, t);
    n_chk++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL par_even_03: %b, required 0", p); end
    push(2, 8'h07);
    rx_frame(2, 16, 1, 1, 1, p, l, t);
    n_chk++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL par_odd_07: %b, required 0", p); end
  endtask
  task automatic test_stop2();
    logic p;
    int l, t0, t1;
    push(3, 8'h55);
    push(3, 8'hC3);
    rx_frame(3, 4, 0, 0, 2, p, l, t0);
    n_chk++;
    if (l != 44) begin n_fail++; $display("FAIL stop2_len: %0d, required 44", l); end
    rx_frame(3, 4, 0, 0, 2, p, l, t1);
    n_chk++;
    if (t1 - t0 != 45) begin n_fail++; $display("FAIL stop2_period: %0d, required 45", t1 - t0); end
  endtask
  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_parity();
    test_stop2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
